psum_bank_ctrl: RTL and testbench

//  Next-generation partial-sum memory controller for the core. It sits between the OFIFO writeback path, the SFU and
//  the external psum readout port, and drives BANKS single-port psum SRAMs (1-cycle read latency, active-low CEN/WEN).
//  It adds an in-memory accumulate mode (read-add-write with RAW forwarding and saturation) and bank interleaving.
//  It also adds a drain/grant handshake so the SFU only takes the memory once all in-flight writebacks have retired.

---
 rtl/psum_bank_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_psum_bank_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_bank_ctrl.sv
// Partial-sum memory controller: writeback pipeline with in-memory accumulate, bank interleaving,
// external readout and an SFU drain/grant handshake in front of BANKS single-port SRAMs.
module psum_bank_ctrl #(
  parameter int col     = 8,
  parameter int psum_bw = 13,
  parameter int ADDR_W  = 11,
  parameter int BANKS   = 2,
  parameter int SAT     = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      wr_valid,
  output logic                                      wr_ready,
  input  logic                                      wr_acc,
  input  logic [ADDR_W-1:0]                         wr_addr,
  input  logic [col*psum_bw-1:0]                    wr_data,
  input  logic                                      ext_rd_req,
  output logic                                      ext_rd_ready,
  input  logic [ADDR_W-1:0]                         ext_addr,
  input  logic                                      sfu_req,
  output logic                                      sfu_grant,
  input  logic                                      sfu_rd,
  input  logic                                      sfu_wr,
  input  logic [ADDR_W-1:0]                         sfu_addr,
  input  logic [col*psum_bw-1:0]                    sfu_wdata,
  output logic                                      rd_valid,
  output logic                                      rd_src,
  output logic [col*psum_bw-1:0]                    rd_data,
  output logic [BANKS-1:0]                          bank_cen,
  output logic [BANKS-1:0]                          bank_wen,
  output logic [BANKS*(ADDR_W-$clog2(BANKS))-1:0]   bank_a,
  output logic [col*psum_bw-1:0]                    bank_d,
  input  logic [BANKS*col*psum_bw-1:0]              bank_q
);

  localparam int BS_W = $clog2(BANKS);
  localparam int BA_W = ADDR_W - BS_W;
  localparam int DW   = col * psum_bw;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SFU} state_t;

  state_t            state_q, state_d;
  logic              s1_valid_q, s1_valid_d, s1_acc_q, s1_acc_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic [DW-1:0]     s1_data_q, s1_data_d;
  logic              s2_valid_q, s2_valid_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic [DW-1:0]     s2_sum_q, s2_sum_d;
  logic              rd_valid_q, rd_valid_d, rd_src_q, rd_src_d;
  logic [BS_W-1:0]   rd_bank_q, rd_bank_d;

  logic              wr_fire, ext_fire, sfu_wr_en, sfu_rd_en;
  logic [DW-1:0]     base, sum;
  logic [DW-1:0]     q_word [BANKS];

  function automatic logic [BS_W-1:0] bank_sel(input logic [ADDR_W-1:0] a);
    return a[BS_W-1:0];
  endfunction

  function automatic logic [BA_W-1:0] bank_row(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:BS_W];
  endfunction

  // One extra bit per lane; overflow shows up as the two top bits disagreeing.
  function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0]    res;
    logic [psum_bw:0] s;
    res = '0;
    for (int i = 0; i < col; i++) begin
      s = {a[i*psum_bw+psum_bw-1], a[i*psum_bw +: psum_bw]}
        + {b[i*psum_bw+psum_bw-1], b[i*psum_bw +: psum_bw]};
      if (SAT != 0 && (s[psum_bw] != s[psum_bw-1]))
        res[i*psum_bw +: psum_bw] = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                               : {1'b0, {(psum_bw-1){1'b1}}};
      else
        res[i*psum_bw +: psum_bw] = s[psum_bw-1:0];
    end
    return res;
  endfunction

  // Reset gates the handshakes so no SRAM access is issued while it is held.
  assign wr_ready     = !reset && (state_q == ST_RUN)
                        && !(s2_valid_q && bank_sel(s2_addr_q) == bank_sel(wr_addr));
  assign wr_fire      = wr_valid && wr_ready;
  assign ext_rd_ready = !reset && (state_q == ST_RUN)
                        && !(s2_valid_q && bank_sel(s2_addr_q) == bank_sel(ext_addr))
                        && !(wr_fire && bank_sel(wr_addr) == bank_sel(ext_addr));
  assign ext_fire     = ext_rd_req && ext_rd_ready;
  assign sfu_grant    = (state_q == ST_SFU);
  assign sfu_wr_en    = sfu_grant && sfu_wr;
  assign sfu_rd_en    = sfu_grant && sfu_rd && !sfu_wr;

  assign bank_d   = s2_valid_q ? s2_sum_q : (sfu_wr_en ? sfu_wdata : '0);
  assign rd_valid = rd_valid_q;
  assign rd_src   = rd_src_q;
  assign rd_data  = rd_valid_q ? q_word[rd_bank_q] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < BANKS; gi++) begin : bank_g
      localparam logic [BS_W-1:0] ID = BS_W'(gi);
      logic            cen_b, wen_b;
      logic [BA_W-1:0] a_b;

      assign q_word[gi] = bank_q[gi*DW +: DW];

      // Fixed priority: retiring write, accumulate read, external read, then SFU.
      always_comb begin
        cen_b = 1'b1;
        wen_b = 1'b1;
        a_b   = '0;
        if (s2_valid_q && bank_sel(s2_addr_q) == ID) begin
          cen_b = 1'b0;
          wen_b = 1'b0;
          a_b   = bank_row(s2_addr_q);
        end else if (wr_fire && wr_acc && bank_sel(wr_addr) == ID) begin
          cen_b = 1'b0;
          a_b   = bank_row(wr_addr);
        end else if (ext_fire && bank_sel(ext_addr) == ID) begin
          cen_b = 1'b0;
          a_b   = bank_row(ext_addr);
        end else if (sfu_wr_en && bank_sel(sfu_addr) == ID) begin
          cen_b = 1'b0;
          wen_b = 1'b0;
          a_b   = bank_row(sfu_addr);
        end else if (sfu_rd_en && bank_sel(sfu_addr) == ID) begin
          cen_b = 1'b0;
          a_b   = bank_row(sfu_addr);
        end
      end

      assign bank_cen[gi]             = cen_b;
      assign bank_wen[gi]             = wen_b;
      assign bank_a[gi*BA_W +: BA_W]  = a_b;
    end
  endgenerate

  always_comb begin
    // s2 holds the previous op, whose write had not landed when s1 read the bank.
    base = (s2_valid_q && s2_addr_q == s1_addr_q) ? s2_sum_q : q_word[bank_sel(s1_addr_q)];
    sum  = s1_acc_q ? lane_add(base, s1_data_q) : s1_data_q;

    s1_valid_d = wr_fire;
    s1_acc_d   = wr_fire ? wr_acc  : s1_acc_q;
    s1_addr_d  = wr_fire ? wr_addr : s1_addr_q;
    s1_data_d  = wr_fire ? wr_data : s1_data_q;
    s2_valid_d = s1_valid_q;
    s2_addr_d  = s1_valid_q ? s1_addr_q : s2_addr_q;
    s2_sum_d   = s1_valid_q ? sum : s2_sum_q;
    rd_valid_d = ext_fire || sfu_rd_en;
    rd_src_d   = sfu_rd_en;
    rd_bank_d  = sfu_rd_en ? bank_sel(sfu_addr) : bank_sel(ext_addr);

    state_d = state_q;
    case (state_q)
      ST_RUN:   if (sfu_req) state_d = ST_DRAIN;
      ST_DRAIN: if (!s1_valid_q && !s2_valid_q) state_d = sfu_req ? ST_SFU : ST_RUN;
      ST_SFU:   if (!sfu_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      s1_valid_q <= 1'b0;
      s1_acc_q   <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_sum_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_src_q   <= 1'b0;
      rd_bank_q  <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_acc_q   <= s1_acc_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_addr_q  <= s2_addr_d;
      s2_sum_q   <= s2_sum_d;
      rd_valid_q <= rd_valid_d;
      rd_src_q   <= rd_src_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

endmodule

// File: tb/tb_psum_bank_ctrl.sv
// Directed bench for psum_bank_ctrl: a saturating and a wrapping instance share stimulus,
// each backed by a behavioural 1-cycle-latency SRAM model per bank.
module tb_psum_bank_ctrl;

  localparam int COL = 8;
  localparam int PBW = 13;
  localparam int AW  = 11;
  localparam int NB  = 2;
  localparam int BA  = 10;
  localparam int DW  = COL * PBW;
  localparam int NW  = 1 << BA;

  logic clk = 1'b0;
  logic reset;
  logic wr_valid, wr_acc, ext_rd_req, sfu_req, sfu_rd, sfu_wr;
  logic [AW-1:0] wr_addr, ext_addr, sfu_addr;
  logic [DW-1:0] wr_data, sfu_wdata;

  logic wr_ready, ext_rd_ready, sfu_grant, rd_valid, rd_src;
  logic [DW-1:0] rd_data, bank_d;
  logic [NB-1:0] bank_cen, bank_wen;
  logic [NB*BA-1:0] bank_a;
  logic [NB*DW-1:0] bank_q;

  logic wr_ready_w, ext_rd_ready_w, sfu_grant_w, rd_valid_w, rd_src_w;
  logic [DW-1:0] rd_data_w, bank_d_w;
  logic [NB-1:0] bank_cen_w, bank_wen_w;
  logic [NB*BA-1:0] bank_a_w;
  logic [NB*DW-1:0] bank_q_w;

  logic [DW-1:0] mem_s [NB][NW];
  logic [DW-1:0] mem_w [NB][NW];

  int vectors = 0;
  int miscompares = 0;
  int stall_i, stall_s, st;

  always #5 clk = ~clk;

  psum_bank_ctrl #(.col(COL), .psum_bw(PBW), .ADDR_W(AW), .BANKS(NB), .SAT(1)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_acc(wr_acc),
    .wr_addr(wr_addr), .wr_data(wr_data), .ext_rd_req(ext_rd_req), .ext_rd_ready(ext_rd_ready),
    .ext_addr(ext_addr), .sfu_req(sfu_req), .sfu_grant(sfu_grant), .sfu_rd(sfu_rd), .sfu_wr(sfu_wr),
    .sfu_addr(sfu_addr), .sfu_wdata(sfu_wdata), .rd_valid(rd_valid), .rd_src(rd_src),
    .rd_data(rd_data), .bank_cen(bank_cen), .bank_wen(bank_wen), .bank_a(bank_a),
    .bank_d(bank_d), .bank_q(bank_q));

  psum_bank_ctrl #(.col(COL), .psum_bw(PBW), .ADDR_W(AW), .BANKS(NB), .SAT(0)) dut_w (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready_w), .wr_acc(wr_acc),
    .wr_addr(wr_addr), .wr_data(wr_data), .ext_rd_req(ext_rd_req), .ext_rd_ready(ext_rd_ready_w),
    .ext_addr(ext_addr), .sfu_req(sfu_req), .sfu_grant(sfu_grant_w), .sfu_rd(sfu_rd), .sfu_wr(sfu_wr),
    .sfu_addr(sfu_addr), .sfu_wdata(sfu_wdata), .rd_valid(rd_valid_w), .rd_src(rd_src_w),
    .rd_data(rd_data_w), .bank_cen(bank_cen_w), .bank_wen(bank_wen_w), .bank_a(bank_a_w),
    .bank_d(bank_d_w), .bank_q(bank_q_w));

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!bank_cen[b]) begin
        if (!bank_wen[b]) mem_s[b][bank_a[b*BA +: BA]] <= bank_d;
        else              bank_q[b*DW +: DW] <= mem_s[b][bank_a[b*BA +: BA]];
      end
      if (!bank_cen_w[b]) begin
        if (!bank_wen_w[b]) mem_w[b][bank_a_w[b*BA +: BA]] <= bank_d_w;
        else                bank_q_w[b*DW +: DW] <= mem_w[b][bank_a_w[b*BA +: BA]];
      end
    end
  end

  function automatic logic [DW-1:0] rep(input int v);
    logic [DW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*PBW +: PBW] = v[PBW-1:0];
    return r;
  endfunction

  function automatic logic [DW-1:0] lanes(input int base);
    logic [DW-1:0] r;
    int v;
    for (int i = 0; i < COL; i++) begin
      v = base + i;
      r[i*PBW +: PBW] = v[PBW-1:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a falling edge; waits a bounded number of cycles for acceptance.
  task automatic do_wb(input logic acc, input int addr, input logic [DW-1:0] data, output int stalls);
    wr_valid = 1'b1;
    wr_acc   = acc;
    wr_addr  = AW'(addr);
    wr_data  = data;
    stalls   = 0;
    #1;
    while (!wr_ready && stalls < 8) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    chk($sformatf("wb_accept_a%0d", addr), {{(DW-1){1'b0}}, wr_ready}, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    wr_acc   = 1'b0;
  endtask

  task automatic do_rd(input string tag, input int addr, input logic [DW-1:0] exp,
                       input logic chk_w, input logic [DW-1:0] exp_w);
    int k;
    ext_rd_req = 1'b1;
    ext_addr   = AW'(addr);
    k = 0;
    #1;
    while (!ext_rd_ready && k < 8) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({tag, "_accept"}, {{(DW-1){1'b0}}, ext_rd_ready}, 1);
    @(negedge clk);
    ext_rd_req = 1'b0;
    #1;
    chk({tag, "_valid"}, {{(DW-1){1'b0}}, rd_valid}, 1);
    chk({tag, "_src"}, {{(DW-1){1'b0}}, rd_src}, 0);
    chk({tag, "_data"}, rd_data, exp);
    if (chk_w) begin
      chk({tag, "_valid_w"}, {{(DW-1){1'b0}}, rd_valid_w}, 1);
      chk({tag, "_data_w"}, rd_data_w, exp_w);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    wr_valid = 0; wr_acc = 0; wr_addr = '0; wr_data = '0;
    ext_rd_req = 0; ext_addr = '0;
    sfu_req = 0; sfu_rd = 0; sfu_wr = 0; sfu_addr = '0; sfu_wdata = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cen", bank_cen, 2'b11);
    chk("rst_wen", bank_wen, 2'b11);
    chk("rst_a", bank_a, 0);
    chk("rst_d", bank_d, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_flags", {rd_valid, rd_src, sfu_grant}, 0);
    chk("rst_flags_w", {rd_valid_w, rd_src_w, sfu_grant_w}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("run_ready", {wr_ready, ext_rd_ready, wr_ready_w, ext_rd_ready_w}, 4'b1111);
    @(negedge clk);

    // T1 overwrite addr 4, read back at t+3
    wr_valid = 1; wr_acc = 0; wr_addr = 11'd4; wr_data = rep(5);
    #1 chk("t1_wr_ready", {{(DW-1){1'b0}}, wr_ready}, 1);
    @(negedge clk);
    wr_valid = 0;
    @(negedge clk);
    ext_rd_req = 1; ext_addr = 11'd4;
    #1;
    chk("t1_rd_blocked", {{(DW-1){1'b0}}, ext_rd_ready}, 0);
    chk("t1_cen", bank_cen, 2'b10);
    chk("t1_wen", bank_wen, 2'b10);
    chk("t1_bank_a", bank_a, 2);
    chk("t1_bank_d", bank_d, rep(5));
    @(negedge clk);
    #1 chk("t1_rd_ready", {{(DW-1){1'b0}}, ext_rd_ready}, 1);
    @(negedge clk);
    ext_rd_req = 0;
    #1;
    chk("t1_rd_valid", {{(DW-1){1'b0}}, rd_valid}, 1);
    chk("t1_rd_src", {{(DW-1){1'b0}}, rd_src}, 0);
    chk("t1_rd_data", rd_data, rep(5));
    @(negedge clk);

    // T2 back-to-back accumulate to the same address (forwarding)
    do_wb(0, 6, rep(10), st);
    repeat (2) @(negedge clk);
    do_wb(1, 6, rep(3), st);
    do_wb(1, 6, rep(4), st);
    repeat (2) @(negedge clk);
    do_rd("t2_rd6", 6, rep(17), 0, '0);

    // T3 saturation vs wrap
    do_wb(0, 10, rep(4090), st);
    do_wb(0, 12, rep(-4090), st);
    repeat (2) @(negedge clk);
    do_wb(1, 10, rep(6), st);
    do_wb(1, 12, rep(-10), st);
    repeat (2) @(negedge clk);
    do_rd("t3_pos", 10, rep(4095), 1, rep(-4096));
    do_rd("t3_neg", 12, rep(-4096), 1, rep(4092));

    // T4 interleaved overwrites, then same-bank accumulates
    stall_i = 0;
    for (int a = 0; a < 8; a++) begin
      do_wb(0, a, lanes(a * 16), st);
      stall_i += st;
    end
    stall_s = 0;
    for (int k = 0; k < 8; k++) begin
      do_wb(1, (k % 4) * 2, rep(100), st);
      stall_s += st;
    end
    chk("t4_same_bank_stalled", {{(DW-1){1'b0}}, stall_s > 0}, 1);
    repeat (2) @(negedge clk);
    for (int a = 0; a < 8; a++)
      do_rd($sformatf("t4_rd%0d", a), a, lanes(a * 16 + ((a % 2 == 0) ? 200 : 0)), 0, '0);

    // T5 SFU request with two writebacks in flight
    wr_valid = 1; wr_acc = 0; wr_addr = 11'd20; wr_data = rep(7);
    #1 chk("t5_wr0_ready", {{(DW-1){1'b0}}, wr_ready}, 1);
    @(negedge clk);
    wr_addr = 11'd21; wr_data = rep(8); sfu_req = 1;
    #1 chk("t5_wr1_ready", {{(DW-1){1'b0}}, wr_ready}, 1);
    @(negedge clk);
    wr_addr = 11'd23; wr_data = rep(9); ext_rd_req = 1; ext_addr = 11'd21;
    #1;
    chk("t5_drain_wr_ready", {{(DW-1){1'b0}}, wr_ready}, 0);
    chk("t5_drain_ext_ready", {{(DW-1){1'b0}}, ext_rd_ready}, 0);
    chk("t5_drain_grant0", {{(DW-1){1'b0}}, sfu_grant}, 0);
    @(negedge clk);
    wr_valid = 0;
    #1;
    chk("t5_drain_grant1", {{(DW-1){1'b0}}, sfu_grant}, 0);
    chk("t5_drain_wen", bank_wen, 2'b01);
    @(negedge clk);
    #1 chk("t5_drain_grant2", {{(DW-1){1'b0}}, sfu_grant}, 0);
    @(negedge clk);
    sfu_rd = 1; sfu_addr = 11'd21;
    #1;
    chk("t5_grant", {{(DW-1){1'b0}}, sfu_grant}, 1);
    chk("t5_sfu_rd_cen", bank_cen, 2'b01);
    chk("t5_sfu_ext_ready", {{(DW-1){1'b0}}, ext_rd_ready}, 0);
    @(negedge clk);
    sfu_rd = 1; sfu_wr = 1; sfu_addr = 11'd20; sfu_wdata = rep(99);
    #1;
    chk("t5_sfu_rd_valid", {{(DW-1){1'b0}}, rd_valid}, 1);
    chk("t5_sfu_rd_src", {{(DW-1){1'b0}}, rd_src}, 1);
    chk("t5_sfu_rd_data", rd_data, rep(8));
    chk("t5_sfu_wr_wen", bank_wen, 2'b10);
    @(negedge clk);
    sfu_wr = 0; sfu_rd = 1; sfu_addr = 11'd20;
    #1 chk("t5_rdwr_no_read", {{(DW-1){1'b0}}, rd_valid}, 0);
    @(negedge clk);
    sfu_rd = 0; sfu_req = 0;
    #1;
    chk("t5_sfu_rd2_valid", {{(DW-1){1'b0}}, rd_valid}, 1);
    chk("t5_sfu_rd2_src", {{(DW-1){1'b0}}, rd_src}, 1);
    chk("t5_sfu_rd2_data", rd_data, rep(99));
    @(negedge clk);
    #1;
    chk("t5_release_grant", {{(DW-1){1'b0}}, sfu_grant}, 0);
    chk("t5_held_ext_ready", {{(DW-1){1'b0}}, ext_rd_ready}, 1);
    @(negedge clk);
    ext_rd_req = 0;
    #1;
    chk("t5_ext_valid", {{(DW-1){1'b0}}, rd_valid}, 1);
    chk("t5_ext_src", {{(DW-1){1'b0}}, rd_src}, 0);
    chk("t5_ext_data", rd_data, rep(8));
    @(negedge clk);

    // T6 reset with s1 and s2 occupied discards both writes
    do_wb(0, 30, rep(50), st);
    do_wb(0, 31, rep(51), st);
    repeat (2) @(negedge clk);
    do_wb(0, 30, rep(1), st);
    do_wb(0, 31, rep(2), st);
    #1 chk("t6_s2_writing", bank_wen, 2'b10);
    reset = 1'b1;
    #1;
    chk("t6_rst_cen", bank_cen, 2'b11);
    chk("t6_rst_wen", bank_wen, 2'b11);
    chk("t6_rst_a", bank_a, 0);
    chk("t6_rst_d", bank_d, 0);
    chk("t6_rst_rd_data", rd_data, 0);
    chk("t6_rst_flags", {rd_valid, rd_src, sfu_grant}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("t6_run_ready", {{(DW-1){1'b0}}, wr_ready}, 1);
    @(negedge clk);
    do_rd("t6_rd30", 30, rep(50), 0, '0);
    do_rd("t6_rd31", 31, rep(51), 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
